// File: rtl/mux_nx1_scan.sv
// Registered N:1 mux with direct select or auto-scan (per-channel dwell); optional parity output under MUX_PARITY_EN.
// Latency 1 cycle, all outputs registered; no backpressure, the consumer samples every clock.
module mux_nx1_scan #(
   parameter int N     = 8,
   parameter int W     = 1,
   parameter int DWELL = 1,
   localparam int SW   = $clog2(N)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            en,
   input  logic            mode,
   input  logic [SW-1:0]   s,
   input  logic [N*W-1:0]  datain,
   output logic [W-1:0]    dataout,
   output logic [SW-1:0]   ch,
   output logic            valid,
   output logic            wrap
`ifdef MUX_PARITY_EN
   ,
   output logic            parity
`endif
);

   localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);
   localparam logic [SW-1:0] PTR_LAST = SW'(N - 1);
   localparam logic [SW:0]   N_W      = (SW + 1)'(N);

   typedef enum logic {IDLE, SCAN} state_t;

   state_t          state_q, state_d;
   logic [SW-1:0]   ptr_q, ptr_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [W-1:0]    dataout_q, dataout_d;
   logic [SW-1:0]   ch_q, ch_d;
   logic            valid_q, valid_d;
   logic            wrap_q, wrap_d;
   logic            parity_q, parity_d;

   logic [SW-1:0]   eff_ptr;
   logic [CW-1:0]   eff_cnt;
   logic [SW-1:0]   sel;
   logic [W-1:0]    chan;

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      cnt_d     = cnt_q;
      dataout_d = '0;
      ch_d      = ch_q;
      valid_d   = 1'b0;
      wrap_d    = 1'b0;

      // Any cycle spent outside SCAN makes the next scan start from channel 0.
      eff_ptr = (state_q == SCAN) ? ptr_q : '0;
      eff_cnt = (state_q == SCAN) ? cnt_q : '0;
      sel     = mode ? eff_ptr : s;

      chan = '0;
      for (int k = 0; k < N; k++) begin
         if (sel == SW'(k)) chan = datain[k*W +: W];
      end

      if (en) begin
         state_d = IDLE;
         ptr_d   = '0;
         cnt_d   = '0;
      end else if (!mode) begin
         state_d = IDLE;
         ptr_d   = '0;
         cnt_d   = '0;
         ch_d    = s;
         if ({1'b0, s} < N_W) begin
            dataout_d = chan;
            valid_d   = 1'b1;
         end
      end else begin
         state_d   = SCAN;
         dataout_d = chan;
         ch_d      = eff_ptr;
         valid_d   = 1'b1;
         if (eff_cnt == CNT_LAST) begin
            cnt_d = '0;
            if (eff_ptr == PTR_LAST) begin
               ptr_d  = '0;
               wrap_d = 1'b1;
            end else begin
               ptr_d = eff_ptr + 1'b1;
            end
         end else begin
            cnt_d = eff_cnt + 1'b1;
            ptr_d = eff_ptr;
         end
      end

      parity_d = ^dataout_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         ptr_q     <= '0;
         cnt_q     <= '0;
         dataout_q <= '0;
         ch_q      <= '0;
         valid_q   <= 1'b0;
         wrap_q    <= 1'b0;
         parity_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         cnt_q     <= cnt_d;
         dataout_q <= dataout_d;
         ch_q      <= ch_d;
         valid_q   <= valid_d;
         wrap_q    <= wrap_d;
         parity_q  <= parity_d;
      end
   end

   assign dataout = dataout_q;
   assign ch      = ch_q;
   assign valid   = valid_q;
   assign wrap    = wrap_q;
`ifdef MUX_PARITY_EN
   assign parity  = parity_q;
`else
   logic unused_parity;
   assign unused_parity = parity_q;
`endif

endmodule

// File: tb/tb_mux_nx1_scan.sv
// Directed bench for mux_nx1_scan: three instances (N=8/W=1/DWELL=1, N=4/W=4/DWELL=3, N=6/W=1/DWELL=2).
module tb_mux_nx1_scan;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   // Instance A: N=8, W=1, DWELL=1
   logic       a_en, a_mode;
   logic [2:0] a_s;
   logic [7:0] a_din;
   logic       a_dout, a_valid, a_wrap, a_par;
   logic [2:0] a_ch;

   // Instance B: N=4, W=4, DWELL=3
   logic        b_en, b_mode;
   logic [1:0]  b_s;
   logic [15:0] b_din;
   logic [3:0]  b_dout;
   logic [1:0]  b_ch;
   logic        b_valid, b_wrap, b_par;

   // Instance C: N=6, W=1, DWELL=2 (non power of two)
   logic       c_en, c_mode;
   logic [2:0] c_s;
   logic [5:0] c_din;
   logic       c_dout, c_valid, c_wrap, c_par;
   logic [2:0] c_ch;

   mux_nx1_scan #(.N(8), .W(1), .DWELL(1)) u_a (
      .clk(clk), .rst_n(rst_n), .en(a_en), .mode(a_mode), .s(a_s), .datain(a_din),
      .dataout(a_dout), .ch(a_ch), .valid(a_valid), .wrap(a_wrap)
`ifdef MUX_PARITY_EN
      , .parity(a_par)
`endif
   );

   mux_nx1_scan #(.N(4), .W(4), .DWELL(3)) u_b (
      .clk(clk), .rst_n(rst_n), .en(b_en), .mode(b_mode), .s(b_s), .datain(b_din),
      .dataout(b_dout), .ch(b_ch), .valid(b_valid), .wrap(b_wrap)
`ifdef MUX_PARITY_EN
      , .parity(b_par)
`endif
   );

   mux_nx1_scan #(.N(6), .W(1), .DWELL(2)) u_c (
      .clk(clk), .rst_n(rst_n), .en(c_en), .mode(c_mode), .s(c_s), .datain(c_din),
      .dataout(c_dout), .ch(c_ch), .valid(c_valid), .wrap(c_wrap)
`ifdef MUX_PARITY_EN
      , .parity(c_par)
`endif
   );

`ifndef MUX_PARITY_EN
   assign a_par = 1'b0;
   assign b_par = 1'b0;
   assign c_par = 1'b0;
`endif

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_a(input string tag, input logic d, input logic [2:0] c,
                        input logic v, input logic w);
      chk({tag, ".dout"}, 32'(a_dout), 32'(d));
      chk({tag, ".ch"}, 32'(a_ch), 32'(c));
      chk({tag, ".valid"}, 32'(a_valid), 32'(v));
      chk({tag, ".wrap"}, 32'(a_wrap), 32'(w));
`ifdef MUX_PARITY_EN
      chk({tag, ".parity"}, 32'(a_par), 32'(d));
`endif
   endtask

   logic [7:0]  pat8;
   logic [15:0] pat16;

   initial begin
      a_en = 1'b0; a_mode = 1'b0; a_s = 3'd3; a_din = 8'hFF;
      b_en = 1'b0; b_mode = 1'b1; b_s = 2'd0; b_din = 16'hA5C3;
      c_en = 1'b1; c_mode = 1'b0; c_s = 3'd0; c_din = 6'b100000;
      pat8 = 8'h0C;
      pat16 = 16'hA5C3;

      // Held in reset while inputs toggle: everything stays 0.
      repeat (2) step();
      chk_a("rst_hold.a", 1'b0, 3'd0, 1'b0, 1'b0);
      chk("rst_hold.b.dout", 32'(b_dout), 32'h0);
      chk("rst_hold.b.valid", 32'(b_valid), 32'h0);
      rst_n = 1'b1;

      // Direct mode, datain=0C, s=0..7
      a_din = 8'h0C; b_en = 1'b1;
      for (int i = 0; i < 8; i++) begin
         a_s = 3'(i);
         step();
         chk_a($sformatf("direct_s%0d", i), pat8[i], 3'(i), 1'b1, 1'b0);
      end

      // Disable then re-enable with s=2
      a_en = 1'b1;
      step();
      chk_a("disable", 1'b0, 3'd7, 1'b0, 1'b0);
      a_en = 1'b0; a_s = 3'd2;
      step();
      chk_a("reenable_s2", 1'b1, 3'd2, 1'b1, 1'b0);

      // Scan, DWELL=1: ch 0..7 then 0
      a_mode = 1'b1;
      for (int i = 0; i < 9; i++) begin
         step();
         chk_a($sformatf("scan8_%0d", i), pat8[i % 8], 3'(i % 8), 1'b1, (i % 8) == 7);
      end
      step(); chk_a("scan8_ch1", 1'b0, 3'd1, 1'b1, 1'b0);
      step(); chk_a("scan8_ch2", 1'b1, 3'd2, 1'b1, 1'b0);

      // One-cycle disable mid-scan, then restart at channel 0
      a_en = 1'b1;
      step(); chk_a("irq_en", 1'b0, 3'd2, 1'b0, 1'b0);
      a_en = 1'b0;
      step(); chk_a("irq_en_restart0", 1'b0, 3'd0, 1'b1, 1'b0);
      step(); chk_a("irq_en_ch1", 1'b0, 3'd1, 1'b1, 1'b0);
      step(); chk_a("irq_en_ch2", 1'b1, 3'd2, 1'b1, 1'b0);

      // One-cycle direct sample of channel 5 mid-scan, then restart at 0
      a_mode = 1'b0; a_s = 3'd5; a_din = 8'h2C;
      step(); chk_a("irq_mode_s5", 1'b1, 3'd5, 1'b1, 1'b0);
      a_mode = 1'b1;
      step(); chk_a("irq_mode_restart0", 1'b0, 3'd0, 1'b1, 1'b0);
      step(); chk_a("irq_mode_ch1", 1'b0, 3'd1, 1'b1, 1'b0);

      // Disable wins over a simultaneous mode toggle
      a_en = 1'b1; a_mode = 1'b0;
      step(); chk_a("disable_wins", 1'b0, 3'd1, 1'b0, 1'b0);

      // Scan, N=4, W=4, DWELL=3, datain=A5C3: 3,3,3,C,C,C,5,5,5,A,A,A repeating
      b_en = 1'b0;
      for (int i = 0; i < 24; i++) begin
         automatic int k = (i / 3) % 4;
         step();
         chk($sformatf("scan4_%0d.dout", i), 32'(b_dout), 32'(pat16[k*4 +: 4]));
         chk($sformatf("scan4_%0d.ch", i), 32'(b_ch), 32'(k));
         chk($sformatf("scan4_%0d.valid", i), 32'(b_valid), 32'h1);
         chk($sformatf("scan4_%0d.wrap", i), 32'(b_wrap), 32'((i % 12) == 11));
`ifdef MUX_PARITY_EN
         chk($sformatf("scan4_%0d.parity", i), 32'(b_par), 32'h0);
`endif
      end

      // Live datain mid-dwell: change lands on the next edge
      b_din = 16'hA5C7;
      step();
      chk("scan4_live.dout", 32'(b_dout), 32'h7);
      chk("scan4_live.ch", 32'(b_ch), 32'h0);
`ifdef MUX_PARITY_EN
      chk("scan4_live.parity", 32'(b_par), 32'h1);
`endif

      // N=6: direct in-range and out-of-range selects
      c_en = 1'b0; c_mode = 1'b0; c_s = 3'd5;
      step();
      chk("n6_s5.dout", 32'(c_dout), 32'h1);
      chk("n6_s5.valid", 32'(c_valid), 32'h1);
      chk("n6_s5.ch", 32'(c_ch), 32'h5);
      c_s = 3'd6;
      step();
      chk("n6_s6.dout", 32'(c_dout), 32'h0);
      chk("n6_s6.valid", 32'(c_valid), 32'h0);
      chk("n6_s6.ch", 32'(c_ch), 32'h6);
      chk("n6_s6.wrap", 32'(c_wrap), 32'h0);
      c_s = 3'd7;
      step();
      chk("n6_s7.valid", 32'(c_valid), 32'h0);
      chk("n6_s7.ch", 32'(c_ch), 32'h7);

      // N=6 scan with DWELL=2: each channel twice, wrap on second ch5
      c_mode = 1'b1;
      for (int i = 0; i < 14; i++) begin
         automatic int k = (i / 2) % 6;
         step();
         chk($sformatf("scan6_%0d.ch", i), 32'(c_ch), 32'(k));
         chk($sformatf("scan6_%0d.dout", i), 32'(c_dout), 32'(k == 5));
         chk($sformatf("scan6_%0d.wrap", i), 32'(c_wrap), 32'(i == 11));
      end

      // Asynchronous reset mid-scan, between clock edges
      a_en = 1'b0; a_mode = 1'b1; a_din = 8'hFF;
      step(); step();
      #2 rst_n = 1'b0;
      #1;
      chk_a("async_rst.a", 1'b0, 3'd0, 1'b0, 1'b0);
      chk("async_rst.b.dout", 32'(b_dout), 32'h0);
      chk("async_rst.b.ch", 32'(b_ch), 32'h0);
      chk("async_rst.b.valid", 32'(b_valid), 32'h0);
      chk("async_rst.b.wrap", 32'(b_wrap), 32'h0);
      chk("async_rst.c.ch", 32'(c_ch), 32'h0);
      chk("async_rst.c.valid", 32'(c_valid), 32'h0);
`ifdef MUX_PARITY_EN
      chk("async_rst.b.parity", 32'(b_par), 32'h0);
`endif

      // After release, scan restarts at channel 0
      #2 rst_n = 1'b1;
      step();
      chk_a("post_rst.a", 1'b1, 3'd0, 1'b1, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mux_nx1_scan.md
Name: mux_nx1_scan

Overview:
- Parametrised, registered N:1 multiplexer for W-bit channels with an active-low enable.
- Two modes: direct mode, where an external select picks the channel, and scan mode, where an internal counter steps through all channels.
- Each channel is held for a programmable dwell time in scan mode.
- Sits between parallel sources and a single serial consumer. The consumer reads dataout/ch/valid every clock.

Parameters:
- N, 8, number of input channels (N >= 2).
- W, 1, width of each channel in bits (W >= 1).
- DWELL, 1, cycles each channel is presented in scan mode (DWELL >= 1).
- SW (localparam), $clog2(N), select/pointer width.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous reset, active low.
- en  input  1  enable, active low (0 = operate, 1 = disabled).
- mode  input  1  0 = direct select, 1 = auto-scan.
- s  input  SW  channel select, used in direct mode only.
- datain  input  N*W  packed channels; channel k = datain[k*W +: W].
- dataout  output  W  registered selected channel.
- ch  output  SW  index of the channel currently on dataout.
- valid  output  1  dataout holds a legitimate sample.
- wrap  output  1  one-cycle pulse on the last dwell cycle of channel N-1 in scan mode.

Behaviour:
- All outputs are registered, with 1-cycle latency from inputs sampled at a clock edge.
- Reset (rst_n=0, asynchronous): dataout=0, ch=0, valid=0, wrap=0, scan pointer=0, dwell counter=0, FSM=IDLE. The block leaves reset on the first edge after rst_n=1.
- FSM states: IDLE and SCAN.
  - IDLE -> SCAN when en=0 and mode=1.
  - SCAN -> IDLE when en=1 or mode=0.
  - Every entry into SCAN restarts the pointer at 0 and the dwell counter at 0.
- Disabled (en=1), any mode: next edge gives dataout=0, valid=0, wrap=0; ch holds its last value.
- Direct (en=0, mode=0):
  - For s < N: dataout <= channel s, ch <= s, valid <= 1, wrap <= 0.
  - For s >= N (only possible when N is not a power of 2): dataout <= 0, valid <= 0, ch <= s.
- Scan (en=0, mode=1), each cycle:
  - dataout <= channel ptr, ch <= ptr, valid <= 1.
  - The dwell counter increments. When it reaches DWELL-1 it clears and ptr advances.
  - When ptr = N-1 it wraps to 0, and wrap <= 1 for that cycle only.
  - With DWELL=1, ptr advances every cycle.
- datain is sampled live in scan mode: a change mid-dwell appears on the next edge.
- Mode change mid-scan: direct-mode output takes effect on the next edge. A later return to scan restarts at channel 0.
- en deasserted mid-scan: output cleared next edge. Re-enable restarts at channel 0 (no resume).
- Simultaneous en=1 and mode toggle: disable wins.
- Reset asserted mid-scan overrides everything immediately.
- No combinational path from any input to any output.

Optional Feature:
- Macro: MUX_PARITY_EN.
- Defined:
  - Extra output port `parity` (1 bit, registered), equal to the XOR of all W bits of the value loaded into dataout in the same cycle.
  - parity=0 on reset and while disabled.
- Undefined: port absent; no parity logic.

Test Plan:
- Reset: drive traffic, then pull rst_n=0 between clock edges. All outputs must be 0 immediately, before the next edge.
- Direct, N=8, W=1, en=0, mode=0, datain=8'h0C, s=0..7 one per cycle:
  - dataout = 0,0,1,1,0,0,0,0, each one cycle after its select.
  - ch tracks s; valid=1; wrap=0.
- Disable: from the previous case set en=1. Next edge gives dataout=0, valid=0, ch held. Set en=0 with s=2: next edge gives dataout=1, valid=1.
- Scan, N=8, W=1, DWELL=1, datain=8'h0C, en=0, mode=1:
  - ch = 0..7 then 0.
  - dataout = 0,0,1,1,0,0,0,0.
  - wrap=1 only while ch=7.
- Scan, N=4, W=4, DWELL=3, datain=16'hA5C3:
  - dataout = 3,3,3,C,C,C,5,5,5,A,A,A.
  - wrap=1 only on the third A cycle.
  - Then the sequence repeats from 3.
- Interrupt mid-scan: at ch=2, pulse en=1 for one cycle, then en=0.
  - Output 0/valid 0 for one cycle, then scan restarts at ch=0.
  - Repeat using mode=0 for one cycle with s=5: one direct sample of channel 5, then restart at ch=0.
  - With MUX_PARITY_EN, N=4, W=4, datain=16'hA5C3 gives parity = 0,0,0,0 (3, C, 5 and A all have even parity).
